// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control sequencer: one datapath step per cycle, Moore strobes.
// Optional performance counters enabled by defining MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             mem_2_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_src,
  output logic             instr_retired,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_ALU   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_e state_q, state_d;

  // Async reset returns to RESET, whose decode forces every strobe low at once.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    mem_2_reg     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 1'b0;
    instr_retired = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JUMP;
          default:            state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write     = 1'b1;
        mem_2_reg     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b01;
        alu_op        = 2'b01;
        pc_src        = 1'b1;
        pc_write      = zero;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write      = 1'b1;
        pc_src        = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_ILLEGAL: illegal = 1'b1;
      default:   state_d = S_RESET;
    endcase
  end

  assign state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (state_q != S_RESET) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (instr_retired)      instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; counter expectations follow MULTICYCLE_CTRL_PERF_CNT_EN.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int unsigned CW = 4;

  logic          clk, arst, zero, mem_ready;
  logic [6:0]    opcode;
  logic          ir_write, pc_write, reg_write, mem_read, mem_write, iord, mem_2_reg;
  logic [1:0]    alu_src_a, alu_src_b, alu_op;
  logic          pc_src, instr_retired, illegal;
  logic [3:0]    state;
  logic [CW-1:0] cycle_cnt, instr_cnt;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .arst(arst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .mem_2_reg(mem_2_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .instr_retired(instr_retired), .illegal(illegal), .state(state),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] strobes();
    return {ir_write, pc_write, reg_write, mem_read, mem_write, iord, mem_2_reg,
            instr_retired, alu_src_a, alu_src_b, alu_op, pc_src, illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1; mem_ready = 1'b0; opcode = 7'd0; zero = 1'b0;
    step();
    step();
    arst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (strobes() !== 17'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", strobes()); end
    total++; if ({cycle_cnt, instr_cnt} !== '0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cycle_cnt, instr_cnt); end
    mem_ready = 1'b0;
    step();
    total++; if (state !== 4'd1) begin bad++; $display("FAIL reset_to_fetch got=%0d exp=1", state); end
    total++; if ({mem_read, iord, alu_src_a, alu_src_b, alu_op, ir_write, pc_write} !== 10'b1_0_00_01_00_0_0) begin
      bad++; $display("FAIL fetch_wait_outputs got=%b exp=1000010000", {mem_read, iord, alu_src_a, alu_src_b, alu_op, ir_write, pc_write});
    end
    step();
    total++; if (state !== 4'd1) begin bad++; $display("FAIL fetch_hold got=%0d exp=1", state); end
  endtask

  task automatic test_rtype();
    int exp_s[5] = '{1, 2, 7, 9, 1};
    int rets = 0;
    do_reset();
    opcode = 7'b0110011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        total++; if ({ir_write, pc_write, pc_src} !== 3'b000) begin bad++; $display("FAIL rtype_pre got=%b exp=000", {ir_write, pc_write, pc_src}); end
      end
      step();
      total++; if (state !== exp_s[i][3:0]) begin bad++; $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
      total++; if (reg_write !== (exp_s[i] == 9)) begin bad++; $display("FAIL rtype_reg_write[%0d] got=%b", i, reg_write); end
      if (i == 0) begin
        total++; if ({ir_write, pc_write, pc_src} !== 3'b110) begin bad++; $display("FAIL rtype_fetch_ready got=%b exp=110", {ir_write, pc_write, pc_src}); end
      end
      if (i == 2) begin
        total++; if ({alu_src_a, alu_src_b, alu_op} !== 6'b01_00_10) begin bad++; $display("FAIL rtype_exec got=%b exp=010010", {alu_src_a, alu_src_b, alu_op}); end
      end
      if (instr_retired) rets++;
    end
    total++; if (rets !== 1) begin bad++; $display("FAIL rtype_retire got=%0d exp=1", rets); end
    total++; if (instr_cnt !== (PERF ? 4'd1 : 4'd0)) begin bad++; $display("FAIL rtype_instr_cnt got=%0d exp=%0d", instr_cnt, PERF ? 1 : 0); end
    total++; if (cycle_cnt !== (PERF ? 4'd4 : 4'd0)) begin bad++; $display("FAIL rtype_cycle_cnt got=%0d exp=%0d", cycle_cnt, PERF ? 4 : 0); end
  endtask

  task automatic test_load_wait();
    int exp_s[9] = '{1, 2, 3, 4, 4, 4, 4, 5, 1};
    logic rdy[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int rd_cycles = 0;
    do_reset();
    opcode = 7'b0000011;
    step();
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy[i];
      #1;
      total++; if (state !== exp_s[i][3:0]) begin bad++; $display("FAIL load_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
      if (mem_read && iord) rd_cycles++;
      if (i == 7) begin
        total++; if ({reg_write, mem_2_reg, instr_retired} !== 3'b111) begin bad++; $display("FAIL load_wb got=%b exp=111", {reg_write, mem_2_reg, instr_retired}); end
      end
      if (i < 8) step();
    end
    total++; if (rd_cycles !== 4) begin bad++; $display("FAIL load_read_cycles got=%0d exp=4", rd_cycles); end
  endtask

  task automatic test_store();
    int exp_s[5] = '{1, 2, 3, 6, 1};
    do_reset();
    opcode = 7'b0100011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (state !== exp_s[i][3:0]) begin bad++; $display("FAIL store_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
      if (i == 3) begin
        total++; if ({mem_write, iord, instr_retired, mem_read} !== 4'b1110) begin bad++; $display("FAIL store_mem_wr got=%b exp=1110", {mem_write, iord, instr_retired, mem_read}); end
      end
    end
  endtask

  task automatic test_branch(input logic z);
    int exp_s[4] = '{1, 2, 10, 1};
    do_reset();
    opcode = 7'b1100011; mem_ready = 1'b1; zero = z;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (state !== exp_s[i][3:0]) begin bad++; $display("FAIL branch%0d_state[%0d] got=%0d exp=%0d", z, i, state, exp_s[i]); end
      if (i == 2) begin
        total++; if ({pc_write, pc_src, instr_retired, alu_op} !== {z, 4'b1101}) begin
          bad++; $display("FAIL branch%0d_outputs got=%b exp=%b", z, {pc_write, pc_src, instr_retired, alu_op}, {z, 4'b1101});
        end
      end
    end
    total++; if (instr_cnt !== (PERF ? 4'd1 : 4'd0)) begin bad++; $display("FAIL branch%0d_instr_cnt got=%0d", z, instr_cnt); end
  endtask

  task automatic test_jump();
    int exp_s[4] = '{1, 2, 11, 1};
    do_reset();
    opcode = 7'b1101111; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (state !== exp_s[i][3:0]) begin bad++; $display("FAIL jump_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
      if (i == 2) begin
        total++; if ({pc_write, pc_src, instr_retired, reg_write} !== 4'b1110) begin bad++; $display("FAIL jump_outputs got=%b exp=1110", {pc_write, pc_src, instr_retired, reg_write}); end
      end
    end
  endtask

  task automatic test_illegal();
    int bad_cycles = 0;
    do_reset();
    opcode = 7'h7F; mem_ready = 1'b1;
    step(); step(); step();
    total++; if (state !== 4'd12) begin bad++; $display("FAIL illegal_enter got=%0d exp=12", state); end
    for (int i = 0; i < 20; i++) begin
      step();
      if (state !== 4'd12 || strobes() !== 17'd1) bad_cycles++;
    end
    total++; if (bad_cycles !== 0) begin bad++; $display("FAIL illegal_hold bad_cycles got=%0d exp=0", bad_cycles); end
    total++; if (cycle_cnt !== (PERF ? 4'd6 : 4'd0)) begin bad++; $display("FAIL illegal_cycle_cnt got=%0d exp=%0d", cycle_cnt, PERF ? 6 : 0); end
    total++; if (instr_cnt !== 4'd0) begin bad++; $display("FAIL illegal_instr_cnt got=%0d exp=0", instr_cnt); end
    do_reset();
    total++; if ({state, illegal} !== 5'd0) begin bad++; $display("FAIL illegal_cleared got=%0d/%b exp=0/0", state, illegal); end
  endtask

  task automatic test_abort();
    do_reset();
    opcode = 7'b0100011; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    step(); step();
    total++; if ({state, mem_write} !== 5'b0110_1) begin bad++; $display("FAIL abort_pre got=%0d/%b exp=6/1", state, mem_write); end
    #2 arst = 1'b1;
    #1;
    total++; if ({mem_write, instr_retired, state} !== 6'd0) begin bad++; $display("FAIL abort_async got=%b exp=0", {mem_write, instr_retired, state}); end
    total++; if ({cycle_cnt, instr_cnt} !== '0) begin bad++; $display("FAIL abort_cnt got=%0d/%0d exp=0/0", cycle_cnt, instr_cnt); end
    step();
    arst = 1'b0;
  endtask

  task automatic test_wrap();
    int nz = 0;
    do_reset();
    opcode = 7'b0110011; mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if ({cycle_cnt, instr_cnt} !== '0) nz++;
    end
    if (PERF) begin
      total++; if (cycle_cnt !== 4'd15) begin bad++; $display("FAIL wrap_pre got=%0d exp=15", cycle_cnt); end
      step();
      total++; if (cycle_cnt !== 4'd0) begin bad++; $display("FAIL wrap_cycle_cnt got=%0d exp=0", cycle_cnt); end
      total++; if (instr_cnt !== 4'd4) begin bad++; $display("FAIL wrap_instr_cnt got=%0d exp=4", instr_cnt); end
    end else begin
      total++; if (nz !== 0) begin bad++; $display("FAIL counters_tied got=%0d nonzero cycles exp=0", nz); end
    end
  endtask

  initial begin
    arst = 1'b1; mem_ready = 1'b0; opcode = 7'd0; zero = 1'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jump();
    test_illegal();
    test_abort();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Finite-state sequencer for the multicycle variant of the RISC-V datapath.
- Drives the shared ALU, the single instruction/data memory port, the PC, the IR and the register file, one step per cycle.
- Decodes the same opcode set and ALUOp encoding as the single-cycle control unit.
- Sits between the memory handshake and the datapath muxes; replaces the single-cycle control path when the multicycle build is selected.

## Interface

- CNT_W, 32, width of the performance counters.
- clk  in  1  clock; all state changes on the rising edge.
- arst  in  1  asynchronous, active-high reset.
- opcode  in  7  IR[6:0], valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- ir_write, pc_write, reg_write, mem_read, mem_write, iord, mem_2_reg  out  1 each  datapath strobes and selects.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = rs1, 10 = old PC.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  ALUOp: 00 = ADD, 01 = SUB, 10 = R-type.
- pc_src  out  1  PC input select: 0 = ALU result, 1 = ALUOut register.
- instr_retired  out  1  one-cycle pulse in the final state of each instruction.
- illegal  out  1  sticky flag for an unsupported opcode.
- state  out  4  current state, for debug.
- cycle_cnt, instr_cnt  out  CNT_W each  performance counters (see Configuration).

## Operation

- Outputs are Moore (decoded from state), except where a condition is given below. Any output not listed for a state is 0.
- RESET (0): all outputs 0. Next state: FETCH.
- FETCH (1): mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=0, and go to DECODE.
  - Otherwise hold in FETCH.
  - The datapath latches old PC together with IR.
- DECODE (2): alu_src_a=10, alu_src_b=10, alu_op=00; this precomputes the branch/jump target into ALUOut. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JUMP
  - anything else → ILLEGAL
- MEM_ADDR (3): alu_src_a=01, alu_src_b=10, alu_op=00. Next: MEM_RD for a load, MEM_WR for a store.
- MEM_RD (4): mem_read=1, iord=1. Hold until mem_ready=1, then WB_MEM.
- WB_MEM (5): reg_write=1, mem_2_reg=1, instr_retired=1. Next: FETCH.
- MEM_WR (6): mem_write=1, iord=1. Hold until mem_ready=1; in that cycle instr_retired=1, then go to FETCH.
- EXEC_R (7): alu_src_a=01, alu_src_b=00, alu_op=10. Next: WB_ALU.
- EXEC_I (8): alu_src_a=01, alu_src_b=10, alu_op=00. Next: WB_ALU.
- WB_ALU (9): reg_write=1, mem_2_reg=0, instr_retired=1. Next: FETCH.
- BRANCH (10): alu_src_a=01, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero, instr_retired=1. Next: FETCH.
- JUMP (11): pc_write=1, pc_src=1, instr_retired=1. Next: FETCH. JUMP does not write rd.
- ILLEGAL (12): illegal=1; absorbing state, left only by reset. All strobes stay 0.
- Encodings 13–15 are unreachable; if entered, the next state is RESET.

## Timing

- Reset: every output is 0 and state=0 while arst is high and until the first rising edge after arst falls. That edge enters FETCH.
- Cycles per instruction, with mem_ready tied to 1:
  - R-type and I-type: 4
  - load: 5
  - store: 4
  - branch and jump: 3
- Each cycle mem_ready is held low in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_read and mem_write are held stable for the whole wait; they drop in the cycle after mem_ready=1.
- Asserting arst mid-instruction aborts it immediately: all strobes go to 0 asynchronously, with no partial write-back and no retire pulse.
- mem_ready is ignored in all states other than FETCH, MEM_RD and MEM_WR.

## Configuration

- MULTICYCLE_CTRL_PERF_CNT_EN defined:
  - cycle_cnt increments on every clock edge where state≠RESET.
  - instr_cnt increments on every edge where instr_retired=1.
  - Both counters clear on arst and wrap modulo 2^CNT_W.
  - In ILLEGAL, cycle_cnt keeps counting and instr_cnt freezes.
- MULTICYCLE_CTRL_PERF_CNT_EN undefined: both counter outputs are tied to 0, and no counter flops are synthesized.

## Test plan

- R-type, mem_ready=1: state sequence 1,2,7,9,1. reg_write=1 only in state 9. instr_retired pulses once; instr_cnt=1 after 5 edges from reset release.
- Load with mem_ready held low 3 cycles in MEM_RD: mem_read=1 and iord=1 for exactly 4 cycles, then WB_MEM with mem_2_reg=1. Total 8 cycles.
- Branch with zero=1, then repeated with zero=0: pc_write=1 with pc_src=1 in BRANCH for the first case; pc_write=0 for the second. Both return to FETCH and each retires once.
- Opcode 0x7F: DECODE → ILLEGAL. illegal=1 stays high across 20 cycles with no strobes; after arst, state=0 and illegal=0.
- arst pulsed during MEM_WR with mem_ready=0: mem_write drops to 0 without waiting for a clock edge. No retire pulse; the counters read 0.
- Counter wrap with CNT_W=4 and the macro defined: after 16 counted cycles, cycle_cnt=0. With the macro undefined, both counters read 0 throughout.
